// File: rtl/nvram_backup_ctrl_pkg.sv
// Shared types and constants for the nvram backup controller.
//   state_t : sector-transfer FSM states
//   mode_t  : transfer kind (load image, save every sector, save dirty sectors)
//   SECTOR_BYTES / SEC_LSB : sector size and the nvram address bit where the
//                            sector index starts
//   NVRAM_AW : nvram address width
package nvram_backup_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SEC_LSB      = $clog2(SECTOR_BYTES);
  localparam int NVRAM_AW     = 13;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_NEXT      = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MODE_LOAD       = 2'd0,
    MODE_SAVE_ALL   = 2'd1,
    MODE_SAVE_DIRTY = 2'd2
  } mode_t;

endpackage

// File: rtl/nvram_backup_ctrl_dirty_scan.sv
// Priority encoder over the dirty mask: returns the lowest set bit at an index
// above from_idx (or at/above it when inclusive=1).
//   mask      in  SECTORS  dirty flags
//   from_idx  in  SEC_W    search start index
//   inclusive in  1        1: from_idx itself is a candidate
//   found     out 1        a candidate exists
//   idx       out SEC_W    lowest candidate index (0 when none)
module dirty_scan #(
  parameter int SECTORS = 16,
  parameter int SEC_W   = 4
) (
  input  logic [SECTORS-1:0] mask,
  input  logic [SEC_W-1:0]   from_idx,
  input  logic               inclusive,
  output logic               found,
  output logic [SEC_W-1:0]   idx
);

  logic hit_s;

  // Scan high to low so the lowest qualifying bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = {SEC_W{1'b0}};
    hit_s = 1'b0;
    for (int i = SECTORS - 1; i >= 0; i--) begin
      hit_s = mask[i] & ((i > int'(from_idx)) | (inclusive & (i == int'(from_idx))));
      found = found | hit_s;
      idx   = hit_s ? SEC_W'(i) : idx;
    end
  end

endmodule

// File: rtl/nvram_backup_ctrl.sv
// Save-RAM backup sequencer: moves the 8 KiB nvram to/from the mounted SAV
// image one 512-byte sector at a time over the user_io sd_* handshake, and
// tracks which sectors the core has modified.
// Optional build macro NVRAM_AUTOSAVE_EN: idle-timeout auto-save of dirty
// sectors only (otherwise saves are manual, whole image).
// Ports:
//   clk_sys, reset (async, active-high)
//   img_mounted, img_size    : image mount strobe and size (load on mount)
//   ioctl_download           : ROM download start disables backup
//   save_req                 : manual save request (rising edge)
//   nvram_we, nvram_a        : core writes, used to mark sectors dirty
//   sd_ack / sd_lba, sd_rd, sd_wr : user_io sector handshake
//   bk_ena, bk_busy, bk_reset, dirty : status outputs
module nvram_backup_ctrl
  import nvram_backup_pkg::*;
#(
  parameter int SECTORS         = 16,
  parameter int SEC_W           = 4,
  parameter int AUTOSAVE_CYCLES = 53693175
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                img_mounted,
  input  logic [31:0]         img_size,
  input  logic                ioctl_download,
  input  logic                save_req,
  input  logic                nvram_we,
  input  logic [NVRAM_AW-1:0] nvram_a,
  input  logic                sd_ack,
  output logic [31:0]         sd_lba,
  output logic                sd_rd,
  output logic                sd_wr,
  output logic                bk_ena,
  output logic                bk_busy,
  output logic                bk_reset,
  output logic [SECTORS-1:0]  dirty
);

  state_t             state_r;
  mode_t              mode_r;
  logic [SEC_W-1:0]   idx_r;
  logic [31:0]        sd_lba_r;
  logic               sd_rd_r, sd_wr_r, bk_ena_r, bk_busy_r, bk_reset_r;
  logic [SECTORS-1:0] dirty_r, dirty_set_s, dirty_clr_s;
  logic               load_pend_r, save_pend_r, abort_r, auto_pend_s;
  logic               mnt_prev_r, dl_prev_r, save_prev_r, ack_prev_r;
  logic               mnt_ev_s, dl_ev_s, save_ev_s, ack_rise_s, ack_fall_s;
  logic               ena_eff_s, load_eff_s, save_eff_s, idle_s, abort_ev_s;
  logic               accept_load_s, accept_save_s, accept_auto_s;
  logic [SEC_W-1:0]   sec_s, scan_from_s, scan_idx_s;
  logic               scan_incl_s, scan_found_s;
  logic               unused_s;

  // A zero-size mount is no image at all, so it is not treated as an event.
  assign mnt_ev_s   = img_mounted & ~mnt_prev_r & (img_size != 32'd0);
  assign dl_ev_s    = ioctl_download & ~dl_prev_r;
  assign save_ev_s  = save_req & ~save_prev_r & bk_ena_r;
  assign ack_rise_s = sd_ack & ~ack_prev_r;
  assign ack_fall_s = ~sd_ack & ack_prev_r;
  assign sec_s      = nvram_a[SEC_LSB+SEC_W-1:SEC_LSB];
  assign idle_s     = (state_r == ST_IDLE);

  // Fresh edges are merged with latched pendings so IDLE can start in the
  // same cycle the edge is seen (request appears two cycles after the edge).
  assign ena_eff_s     = (bk_ena_r | mnt_ev_s) & ~dl_ev_s;
  assign load_eff_s    = load_pend_r | mnt_ev_s;
  assign save_eff_s    = save_pend_r | save_ev_s;
  assign accept_load_s = idle_s & ena_eff_s & load_eff_s;
  assign accept_save_s = idle_s & ena_eff_s & ~load_eff_s & save_eff_s;
  assign accept_auto_s = idle_s & ena_eff_s & ~load_eff_s & ~save_eff_s & auto_pend_s & scan_found_s;
  assign abort_ev_s    = dl_ev_s | (mnt_ev_s & (mode_r != MODE_LOAD));

  assign unused_s = ^{nvram_a, 32'(AUTOSAVE_CYCLES)};

  // IDLE searches from sector 0 inclusive; NEXT searches strictly above idx.
  always_comb begin
    if (idle_s) begin
      scan_from_s = {SEC_W{1'b0}};
      scan_incl_s = 1'b1;
    end else begin
      scan_from_s = idx_r;
      scan_incl_s = 1'b0;
    end
  end

  dirty_scan #(.SECTORS(SECTORS), .SEC_W(SEC_W)) u_scan (
    .mask      (dirty_r),
    .from_idx  (scan_from_s),
    .inclusive (scan_incl_s),
    .found     (scan_found_s),
    .idx       (scan_idx_s)
  );

  // Dirty set/clear masks; set is OR-ed in last so it wins a same-cycle clear.
  always_comb begin
    dirty_set_s = {SECTORS{1'b0}};
    dirty_clr_s = {SECTORS{1'b0}};
    if (nvram_we && bk_ena_r) begin
      dirty_set_s[sec_s] = 1'b1;
    end else begin
      dirty_set_s = {SECTORS{1'b0}};
    end
    if ((state_r == ST_WAIT_ACK) && ack_rise_s && (mode_r != MODE_LOAD)) begin
      dirty_clr_s[idx_r] = 1'b1;
    end else if ((state_r == ST_DONE) && (mode_r == MODE_LOAD) && !abort_r) begin
      dirty_clr_s = {SECTORS{1'b1}};
    end else begin
      dirty_clr_s = {SECTORS{1'b0}};
    end
  end

  // Previous-value registers for the edge detectors.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mnt_prev_r  <= 1'b0;
      dl_prev_r   <= 1'b0;
      save_prev_r <= 1'b0;
      ack_prev_r  <= 1'b0;
    end else begin
      mnt_prev_r  <= img_mounted;
      dl_prev_r   <= ioctl_download;
      save_prev_r <= save_req;
      ack_prev_r  <= sd_ack;
    end
  end

  // Backup enable, latched requests and the abort flag for the running transfer.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bk_ena_r    <= 1'b0;
      load_pend_r <= 1'b0;
      save_pend_r <= 1'b0;
      abort_r     <= 1'b0;
    end else begin
      if (dl_ev_s) begin
        bk_ena_r    <= 1'b0;
        load_pend_r <= 1'b0;
        save_pend_r <= 1'b0;
      end else begin
        if (mnt_ev_s) begin
          bk_ena_r <= 1'b1;
        end
        load_pend_r <= ~accept_load_s & (load_pend_r | mnt_ev_s);
        save_pend_r <= ~accept_save_s & (save_pend_r | save_ev_s);
      end
      if (idle_s) begin
        abort_r <= 1'b0;
      end else if (abort_ev_s) begin
        abort_r <= 1'b1;
      end
    end
  end

  // Per-sector dirty flags.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dirty_r <= {SECTORS{1'b0}};
    end else begin
      dirty_r <= (dirty_r & ~dirty_clr_s) | dirty_set_s;
    end
  end

`ifdef NVRAM_AUTOSAVE_EN
  logic [31:0] auto_cnt_r;
  logic        auto_pend_r;
  logic        auto_dec_s;

  assign auto_dec_s  = (dirty_r != {SECTORS{1'b0}}) & bk_ena_r & (auto_cnt_r != 32'd0);
  assign auto_pend_s = auto_pend_r;

  // Idle timer: any core write restarts it; expiry requests a dirty-only save.
  // A stale request is dropped once nothing is dirty any more.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      auto_cnt_r  <= 32'd0;
      auto_pend_r <= 1'b0;
    end else begin
      if (nvram_we) begin
        auto_cnt_r <= 32'(AUTOSAVE_CYCLES);
      end else if (auto_dec_s) begin
        auto_cnt_r <= auto_cnt_r - 32'd1;
      end
      if (accept_auto_s || dl_ev_s || (dirty_r == {SECTORS{1'b0}})) begin
        auto_pend_r <= 1'b0;
      end else if (auto_dec_s && !nvram_we && (auto_cnt_r == 32'd1)) begin
        auto_pend_r <= 1'b1;
      end
    end
  end
`else
  assign auto_pend_s = 1'b0;
`endif

  // Sector transfer FSM; every handshake output is a register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      mode_r     <= MODE_LOAD;
      idx_r      <= {SEC_W{1'b0}};
      sd_lba_r   <= 32'd0;
      sd_rd_r    <= 1'b0;
      sd_wr_r    <= 1'b0;
      bk_busy_r  <= 1'b0;
      bk_reset_r <= 1'b0;
    end else begin
      bk_reset_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_load_s) begin
            mode_r    <= MODE_LOAD;
            idx_r     <= {SEC_W{1'b0}};
            state_r   <= ST_REQ;
            bk_busy_r <= 1'b1;
          end else if (accept_save_s) begin
            mode_r    <= MODE_SAVE_ALL;
            idx_r     <= {SEC_W{1'b0}};
            state_r   <= ST_REQ;
            bk_busy_r <= 1'b1;
          end else if (accept_auto_s) begin
            mode_r    <= MODE_SAVE_DIRTY;
            idx_r     <= scan_idx_s;
            state_r   <= ST_REQ;
            bk_busy_r <= 1'b1;
          end else begin
            bk_busy_r <= 1'b0;
          end
        end
        ST_REQ: begin
          sd_lba_r <= 32'(idx_r);
          if (mode_r == MODE_LOAD) begin
            sd_rd_r <= 1'b1;
          end else begin
            sd_wr_r <= 1'b1;
          end
          state_r <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ack_rise_s) begin
            sd_rd_r <= 1'b0;
            sd_wr_r <= 1'b0;
            state_r <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (ack_fall_s) begin
            state_r <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (abort_r || abort_ev_s) begin
            state_r <= ST_DONE;
          end else if (mode_r == MODE_SAVE_DIRTY) begin
            if (scan_found_s) begin
              idx_r   <= scan_idx_s;
              state_r <= ST_REQ;
            end else begin
              state_r <= ST_DONE;
            end
          end else if (idx_r == SEC_W'(SECTORS - 1)) begin
            state_r <= ST_DONE;
          end else begin
            idx_r   <= idx_r + SEC_W'(1);
            state_r <= ST_REQ;
          end
        end
        ST_DONE: begin
          bk_reset_r <= (mode_r == MODE_LOAD) & ~abort_r;
          bk_busy_r  <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          sd_rd_r   <= 1'b0;
          sd_wr_r   <= 1'b0;
          bk_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign sd_lba   = sd_lba_r;
  assign sd_rd    = sd_rd_r;
  assign sd_wr    = sd_wr_r;
  assign bk_ena   = bk_ena_r;
  assign bk_busy  = bk_busy_r;
  assign bk_reset = bk_reset_r;
  assign dirty    = dirty_r;

endmodule
